// File: rtl/tokenizer_pkg.sv
// Shared types and helpers for the greedy longest-match tokenizer.
package tokenizer_pkg;

    localparam int unsigned TM_DATA_WIDTH  = 8;
    localparam int unsigned TM_MAX_TOK_LEN = 4;
    localparam int unsigned TM_EW          = TM_DATA_WIDTH * TM_MAX_TOK_LEN;
    localparam int unsigned TM_LEN_W       = $clog2(TM_MAX_TOK_LEN + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SCAN  = 3'd2,
        EMIT  = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } tm_state_e;

    // Number of leading nonzero characters in a vocab entry (default geometry).
    function automatic logic [TM_LEN_W-1:0] entry_len(input logic [TM_EW-1:0] entry);
        logic [TM_LEN_W-1:0] len;
        logic                run;
        len = '0;
        run = 1'b1;
        for (int k = 0; k < TM_MAX_TOK_LEN; k++) begin
            if (run && (entry[k*TM_DATA_WIDTH +: TM_DATA_WIDTH] != '0)) begin
                len = len + TM_LEN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/tok_compare.sv
// Combinational prefix comparator: does one vocab entry match the head of the window?
module tok_compare #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_TOK_LEN = 4,
    parameter int unsigned LEN_W       = 3
) (
    input  logic [MAX_TOK_LEN*DATA_WIDTH-1:0] window,
    input  logic [LEN_W-1:0]                  win_cnt,
    input  logic [MAX_TOK_LEN*DATA_WIDTH-1:0] entry,
    output logic                              match,
    output logic [LEN_W-1:0]                  len
);

    logic run;
    logic eq;

    // Entry length stops at the first zero byte; only those bytes must equal the window.
    always_comb begin
        len = '0;
        run = 1'b1;
        eq  = 1'b1;
        for (int k = 0; k < MAX_TOK_LEN; k++) begin
            if (run && (entry[k*DATA_WIDTH +: DATA_WIDTH] != '0)) begin
                len = len + LEN_W'(1);
                if (entry[k*DATA_WIDTH +: DATA_WIDTH] != window[k*DATA_WIDTH +: DATA_WIDTH]) begin
                    eq = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
        match = (len != '0) && (len <= win_cnt) && eq;
    end

endmodule

// File: rtl/token_matcher.sv
// Streaming greedy longest-match tokenizer against an external vocab SRAM.
module token_matcher
    import tokenizer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           MAX_TOK_LEN = 4,
    parameter int unsigned           VOCAB_DEPTH = 16,
    parameter int unsigned           CODE_WIDTH  = 8,
    parameter logic [CODE_WIDTH-1:0] UNK_CODE    = 8'hFF,
    localparam int unsigned          VAW = (VOCAB_DEPTH > 1) ? $clog2(VOCAB_DEPTH) : 1,
    localparam int unsigned          EW  = MAX_TOK_LEN * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [VAW-1:0]        vocab_addr,
    input  logic [EW-1:0]         vocab_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CODE_WIDTH-1:0] out_code,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned    LW       = $clog2(MAX_TOK_LEN + 1);
    localparam int unsigned    SCW      = $clog2(VOCAB_DEPTH + 1);
    localparam logic [LW-1:0]  LEN_FULL = LW'(MAX_TOK_LEN);
    localparam logic [SCW-1:0] SCAN_END = SCW'(VOCAB_DEPTH);

    tm_state_e                             state_q, state_d;
    logic [MAX_TOK_LEN-1:0][DATA_WIDTH-1:0] window_q, window_d;
    logic [LW-1:0]                         win_cnt_q, win_cnt_d;
    logic                                  last_seen_q, last_seen_d;
    logic [SCW-1:0]                        scan_cnt_q, scan_cnt_d;
    logic [LW-1:0]                         best_len_q, best_len_d;
    logic [VAW-1:0]                        best_idx_q, best_idx_d;
    logic [LW-1:0]                         consume_q, consume_d;

    logic                  in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
    logic [CODE_WIDTH-1:0] out_code_d;
    logic [VAW-1:0]        vocab_addr_d;

    logic           in_fire, out_fire, upd, fin_unk;
    logic [LW-1:0]  fin_len, fin_consume, rem_cnt;
    logic [VAW-1:0] fin_idx, cmp_idx;
    logic           cmp_match;
    logic [LW-1:0]  cmp_len;

    // Entry read on the previous cycle is compared against the window this cycle.
    tok_compare #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_TOK_LEN (MAX_TOK_LEN),
        .LEN_W       (LW)
    ) u_cmp (
        .window  (window_q),
        .win_cnt (win_cnt_q),
        .entry   (vocab_rdata),
        .match   (cmp_match),
        .len     (cmp_len)
    );

    // Next-state, window/scan bookkeeping and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        win_cnt_d   = win_cnt_q;
        last_seen_d = last_seen_q;
        scan_cnt_d  = scan_cnt_q;
        best_len_d  = best_len_q;
        best_idx_d  = best_idx_q;
        consume_d   = consume_q;
        out_code_d  = out_code;
        out_last_d  = out_last;
        done_d      = done;

        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        cmp_idx     = VAW'(scan_cnt_q - SCW'(1));
        upd         = (scan_cnt_q != '0) && cmp_match && (cmp_len > best_len_q);
        fin_len     = upd ? cmp_len : best_len_q;
        fin_idx     = upd ? cmp_idx : best_idx_q;
        fin_unk     = (fin_len == '0) || (window_q[0] == '0);
        fin_consume = fin_unk ? LW'(1) : fin_len;
        rem_cnt     = win_cnt_q - consume_q;

        if (in_fire) begin
            for (int k = 0; k < MAX_TOK_LEN; k++) begin
                if (LW'(k) == win_cnt_q) window_d[k] = in_data;
            end
            win_cnt_d   = win_cnt_q + LW'(1);
            last_seen_d = in_last;
        end

        case (state_q)
            IDLE: begin
                if (in_fire) state_d = FILL;
            end
            FILL: begin
                if ((win_cnt_q == LEN_FULL) || last_seen_q) begin
                    state_d    = SCAN;
                    scan_cnt_d = '0;
                    best_len_d = '0;
                    best_idx_d = '0;
                end
            end
            SCAN: begin
                best_len_d = fin_len;
                best_idx_d = fin_idx;
                if (scan_cnt_q == SCAN_END) begin
                    state_d    = EMIT;
                    out_code_d = fin_unk ? UNK_CODE : CODE_WIDTH'(fin_idx);
                    consume_d  = fin_consume;
                    out_last_d = last_seen_q && (win_cnt_q == fin_consume);
                end else begin
                    scan_cnt_d = scan_cnt_q + SCW'(1);
                end
            end
            EMIT: begin
                if (out_fire) begin
                    state_d = SHIFT;
                    if (out_last) done_d = 1'b1;
                end
            end
            SHIFT: begin
                for (int k = 0; k < MAX_TOK_LEN; k++) begin
                    window_d[k] = '0;
                    for (int j = 0; j < MAX_TOK_LEN; j++) begin
                        if (j == k + int'(consume_q)) window_d[k] = window_q[j];
                    end
                end
                win_cnt_d = rem_cnt;
                if (!last_seen_q) begin
                    state_d = FILL;
                end else if (rem_cnt != '0) begin
                    state_d    = SCAN;
                    scan_cnt_d = '0;
                    best_len_d = '0;
                    best_idx_d = '0;
                end else begin
                    state_d     = DONE;
                    last_seen_d = 1'b0;
                end
            end
            DONE: begin
                if (in_fire) begin
                    state_d = FILL;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d   = ((state_d == IDLE) || (state_d == FILL) || (state_d == DONE)) &&
                       (win_cnt_d < LEN_FULL) && !last_seen_d;
        busy_d       = !((state_d == IDLE) || (state_d == DONE));
        out_valid_d  = (state_d == EMIT);
        vocab_addr_d = ((state_d == SCAN) && (scan_cnt_d < SCAN_END)) ? VAW'(scan_cnt_d) : '0;
    end

    // State and output registers; reset aborts any scan or pending code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            window_q    <= '0;
            win_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            scan_cnt_q  <= '0;
            best_len_q  <= '0;
            best_idx_q  <= '0;
            consume_q   <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vocab_addr  <= '0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            win_cnt_q   <= win_cnt_d;
            last_seen_q <= last_seen_d;
            scan_cnt_q  <= scan_cnt_d;
            best_len_q  <= best_len_d;
            best_idx_q  <= best_idx_d;
            consume_q   <= consume_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_code    <= out_code_d;
            out_last    <= out_last_d;
            busy        <= busy_d;
            done        <= done_d;
            vocab_addr  <= vocab_addr_d;
        end
    end

endmodule

// File: tb/tb_token_matcher.sv
// Randomized bench for token_matcher with a greedy-tokenizer reference model.
module tb_token_matcher;

    localparam int unsigned MAXL   = 4;
    localparam int unsigned VD     = 16;
    localparam int unsigned EW     = 32;
    localparam int unsigned LAT    = MAXL + VD + 2;
    localparam logic [7:0]  UNK    = 8'hFF;
    localparam int          BUDGET = 3000;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic [3:0]    vocab_addr;
    logic [EW-1:0] vocab_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_code;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [EW-1:0] mem [VD];
    int n_cmp = 0;
    int n_err = 0;

    token_matcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .vocab_addr  (vocab_addr),
        .vocab_rdata (vocab_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Vocab SRAM with one-cycle read latency.
    always @(posedge clk) vocab_rdata <= mem[vocab_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [EW-1:0] mk_entry(input string s);
        logic [EW-1:0] e = '0;
        for (int k = 0; k < s.len() && k < int'(MAXL); k++) e[k*8 +: 8] = s[k];
        return e;
    endfunction

    task automatic default_vocab();
        for (int i = 0; i < int'(VD); i++) mem[i] = '0;
        mem[0] = mk_entry("a");
        mem[1] = mk_entry("ab");
        mem[2] = mk_entry("abc");
        mem[3] = mk_entry("b");
        mem[4] = mk_entry("ca");
    endtask

    function automatic logic [7:0] rnd_char(input int zero_pct);
        int r;
        if (int'($urandom_range(99)) < zero_pct) return 8'h00;
        r = int'($urandom_range(9));
        if (r < 3) return "a";
        if (r < 6) return "b";
        if (r < 8) return "c";
        return "x";
    endfunction

    // Greedy longest match over the stream, computed directly from the matching rules.
    function automatic bq_t ref_codes(input bq_t s);
        bq_t r;
        int  pos = 0;
        int  n   = s.size();
        while (pos < n) begin
            int cnt    = (n - pos < int'(MAXL)) ? n - pos : int'(MAXL);
            int best_l = 0;
            int best_i = 0;
            for (int i = 0; i < int'(VD); i++) begin
                logic [EW-1:0] e = mem[i];
                int  l  = 0;
                bit  ok;
                while (l < int'(MAXL) && e[l*8 +: 8] != 8'h00) l++;
                ok = (l > 0) && (l <= cnt);
                if (ok) for (int k = 0; k < l; k++) if (e[k*8 +: 8] != s[pos+k]) ok = 0;
                if (ok && l > best_l) begin
                    best_l = l;
                    best_i = i;
                end
            end
            if (best_l == 0 || s[pos] == 8'h00) begin
                r.push_back(UNK);
                pos += 1;
            end else begin
                r.push_back(8'(best_i));
                pos += best_l;
            end
        end
        return r;
    endfunction

    task automatic drive(input bq_t s, input int gap_pct);
        int cyc;
        bit timed_out = 0;
        for (int i = 0; i < s.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = (i == s.size() - 1);
            cyc = 0;
            while (!in_ready && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= BUDGET) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("drv_timeout", 32'(timed_out), 0);
    endtask

    task automatic monitor(input bq_t exp, input int rdy_pct, input int stall_first);
        int         idx = 0;
        int         cyc = 0;
        int         stall_left = 0;
        bit         fin = 0;
        bit         stalled = 0;
        bit         held = 0;
        logic [7:0] hc = '0;
        logic       hl = 1'b0;
        while (!fin && cyc < BUDGET) begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_code", 32'(out_code), 32'(hc));
                chk("hold_last", 32'(out_last), 32'(hl));
            end
            if (out_valid && stall_first > 0 && !stalled) begin
                stall_left = stall_first;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                chk("stall_in_ready", 32'(in_ready), 0);
                stall_left--;
            end else begin
                out_ready = (int'($urandom_range(99)) < rdy_pct);
            end
            held = out_valid && !out_ready;
            hc   = out_code;
            hl   = out_last;
            if (out_valid && out_ready) begin
                if (idx < exp.size()) begin
                    chk("code", 32'(out_code), 32'(exp[idx]));
                    chk("last", 32'(out_last), 32'(idx == exp.size() - 1));
                end else begin
                    chk("extra_code", 32'(idx), 32'(exp.size()));
                end
                idx++;
                if (out_last) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("n_codes", 32'(idx), 32'(exp.size()));
    endtask

    task automatic lat_watch();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 200);
        chk("latency", 32'(k), 32'(LAT));
    endtask

    task automatic run_stream(input bq_t s, input int gap_pct, input int rdy_pct,
                              input int stall_first, input bit lat_chk);
        bq_t exp = ref_codes(s);
        fork
            drive(s, gap_pct);
            monitor(exp, rdy_pct, stall_first);
            begin
                if (lat_chk) lat_watch();
            end
        join
        chk("done", 32'(done), 1);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 0);
        chk("in_ready_idle", 32'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_code"}, 32'(out_code), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_vaddr"}, 32'(vocab_addr), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t q;
        int  seen;
        default_vocab();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_stream(str2q("abcab"), 0, 100, 0, 1);
        run_stream(str2q("ax"), 0, 100, 0, 0);

        mem[7] = mk_entry("ab");
        run_stream(str2q("ab"), 0, 100, 0, 0);
        mem[7] = '0;

        run_stream(str2q("abcabc"), 0, 100, 10, 0);

        // Abort a scan with reset, then confirm nothing leaks out afterwards.
        drive(str2q("abca"), 0);
        repeat (6) @(negedge clk);
        chk("busy_scan", 32'(busy), 1);
        chk("vaddr_scan", 32'(vocab_addr), 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("post_rst_valid", 32'(seen), 0);
        run_stream(str2q("b"), 0, 100, 0, 0);

        q = {};
        q.push_back(8'h00);
        run_stream(q, 0, 100, 0, 0);
        run_stream(str2q("ca"), 0, 100, 0, 0);

        for (int t = 0; t < 40; t++) begin
            if (t % 10 == 5) begin
                for (int i = 0; i < int'(VD); i++) begin
                    logic [EW-1:0] e = '0;
                    if ($urandom_range(3) != 0) begin
                        int len = int'($urandom_range(1, MAXL));
                        for (int k = 0; k < len; k++) e[k*8 +: 8] = rnd_char(8);
                    end
                    mem[i] = e;
                end
            end
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 9)); i++) q.push_back(rnd_char(5));
            run_stream(q, int'($urandom_range(0, 40)), int'($urandom_range(30, 100)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
